// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 read/write controllers.
//   - lcdState_t : read-cycle sequencer states
//   - DEF_T_*    : default bus timing, in clock cycles
//   - CMD_*      : HD44780 command bytes used by the write sequencer
//   - BF_BIT     : busy-flag bit position in a status read
//   - maxInt     : helper for sizing the shared cycle timer
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EN_HI   = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4,
        DONE    = 3'd5
    } lcdState_t;

    localparam int DEF_T_AS  = 2;
    localparam int DEF_T_EN  = 12;
    localparam int DEF_T_H   = 2;
    localparam int DEF_T_REC = 10;

    localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CMD_LINE1_ADDR   = 8'h80;
    localparam logic [7:0] CMD_LINE2_ADDR   = 8'hC0;

    localparam int BF_BIT = 7;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer: loadable down-counter shared by the LCD bus sequencers.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load loadVal this cycle (takes priority over counting)
//   loadVal    : value loaded; a state lasting N cycles loads N-1
//   expired    : count has reached 0; the counter parks there
module lcd_cycle_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lcd_read_controller.sv
// lcd_read_controller: one HD44780 8-bit read cycle (RW=1) per request.
//   clk, reset   : clock, synchronous active-high reset
//   iStart       : read request, sampled only while idle
//   iRS          : 0 = busy flag / address counter, 1 = data byte
//   iPoll        : re-read status until BF clears (LCD_BF_POLL_EN only)
//   LCD_DATA_IN  : data pins from the top-level tristate buffer
//   oDATA        : last byte read
//   oBUSY/oADDR  : bit 7 / bits 6:0 of the last status (RS=0) read
//   oTIMEOUT     : poll gave up with BF still set (LCD_BF_POLL_EN only)
//   LCD_DONE     : one-cycle completion pulse
//   oBUS_OWN     : top-level mux select, high from SETUP through RECOVER
//   LCD_RW/EN/RS : LCD control pins
// Optional feature: define LCD_BF_POLL_EN to enable busy-flag polling.
import lcd_pkg::*;

module lcd_read_controller #(
    parameter int T_AS     = DEF_T_AS,
    parameter int T_EN     = DEF_T_EN,
    parameter int T_H      = DEF_T_H,
    parameter int T_REC    = DEF_T_REC,
    parameter int POLL_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    input  logic [7:0] LCD_DATA_IN,
    output logic [7:0] oDATA,
    output logic       oBUSY,
    output logic [6:0] oADDR,
    output logic       oTIMEOUT,
    output logic       LCD_DONE,
    output logic       oBUS_OWN,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int T_MAX = maxInt(maxInt(T_AS, T_EN), maxInt(T_H, T_REC));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LD_EN  = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_H   = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] LD_REC = CNT_W'(T_REC - 1);

    lcdState_t        state;
    logic             rsLat;
    logic [7:0]       capture;
    logic             tmrLoad;
    logic [CNT_W-1:0] tmrLoadVal;
    logic             tmrExpired;
    // High when a status read must be repeated because BF was still set.
    logic             repoll;

    lcd_cycle_timer #(
        .WIDTH(CNT_W)
    ) uTimer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmrLoad),
        .loadVal(tmrLoadVal),
        .expired(tmrExpired)
    );

    // The timer is reloaded on every state entry with the new state's length.
    always_comb begin
        tmrLoad    = 1'b0;
        tmrLoadVal = '0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = LD_AS;
                end
            end
            SETUP: begin
                if (tmrExpired) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = LD_EN;
                end
            end
            EN_HI: begin
                if (tmrExpired) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = LD_H;
                end
            end
            HOLD: begin
                if (tmrExpired) begin
                    tmrLoad    = 1'b1;
                    tmrLoadVal = repoll ? LD_AS : LD_REC;
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered and change on the same edge as the state, so
    // RS/RW are already stable a full T_AS before EN rises and stay put
    // until T_H after it falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rsLat    <= 1'b0;
            capture  <= 8'h00;
            oDATA    <= 8'h00;
            oBUSY    <= 1'b0;
            oADDR    <= 7'h00;
            LCD_DONE <= 1'b0;
            oBUS_OWN <= 1'b0;
            LCD_RW   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
        end else begin
            LCD_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state    <= SETUP;
                        rsLat    <= iRS;
                        LCD_RS   <= iRS;
                        LCD_RW   <= 1'b1;
                        oBUS_OWN <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tmrExpired) begin
                        state  <= EN_HI;
                        LCD_EN <= 1'b1;
                    end
                end
                EN_HI: begin
                    // Sample on the edge that drops EN: the last EN-high cycle.
                    if (tmrExpired) begin
                        state   <= HOLD;
                        LCD_EN  <= 1'b0;
                        capture <= LCD_DATA_IN;
                    end
                end
                HOLD: begin
                    if (tmrExpired) begin
                        if (repoll) begin
                            // Back-to-back status read: RS/RW/bus stay held.
                            state <= SETUP;
                        end else begin
                            state  <= RECOVER;
                            LCD_RW <= 1'b0;
                            LCD_RS <= 1'b0;
                        end
                    end
                end
                RECOVER: begin
                    if (tmrExpired) begin
                        state    <= DONE;
                        oBUS_OWN <= 1'b0;
                        LCD_DONE <= 1'b1;
                        oDATA    <= capture;
                        if (!rsLat) begin
                            oBUSY <= capture[BF_BIT];
                            oADDR <= capture[6:0];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LCD_BF_POLL_EN
    localparam int PC_W = $clog2(POLL_MAX + 1);
    // Count value reached once POLL_MAX reads have been made.
    localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_MAX - 1);

    logic            pollLat;
    logic [PC_W-1:0] pollCnt;
    logic            timeoutPend;
    logic            bfSeen;

    assign bfSeen = pollLat && !rsLat && capture[BF_BIT];
    assign repoll = bfSeen && (pollCnt != POLL_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pollLat     <= 1'b0;
            pollCnt     <= '0;
            timeoutPend <= 1'b0;
            oTIMEOUT    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pollCnt     <= '0;
                    timeoutPend <= 1'b0;
                    if (iStart) begin
                        pollLat <= iPoll;
                    end
                end
                HOLD: begin
                    if (tmrExpired && bfSeen) begin
                        if (pollCnt != POLL_LAST) begin
                            pollCnt <= pollCnt + PC_W'(1);
                        end else begin
                            timeoutPend <= 1'b1;
                        end
                    end
                end
                RECOVER: begin
                    if (tmrExpired) begin
                        oTIMEOUT <= timeoutPend;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unusedPoll;

    assign repoll     = 1'b0;
    assign oTIMEOUT   = 1'b0;
    assign unusedPoll = iPoll ^ (POLL_MAX == 0);
`endif

endmodule

// File: tb/tb_lcd_read_controller.sv
module tb_lcd_read_controller;

    localparam int T_AS  = 2;
    localparam int T_EN  = 12;
    localparam int T_H   = 2;
    localparam int T_REC = 10;
    localparam int TOTAL = 1 + T_AS + T_EN + T_H + T_REC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       iStart = 1'b0;
    logic       iRS = 1'b0;
    logic       iPoll = 1'b0;
    logic [7:0] LCD_DATA_IN = 8'h00;
    logic [7:0] oDATA;
    logic       oBUSY;
    logic [6:0] oADDR;
    logic       oTIMEOUT;
    logic       LCD_DONE;
    logic       oBUS_OWN;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    lcd_read_controller #(
        .T_AS(T_AS), .T_EN(T_EN), .T_H(T_H), .T_REC(T_REC), .POLL_MAX(3)
    ) dut (
        .clk(clk), .reset(reset), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
        .LCD_DATA_IN(LCD_DATA_IN), .oDATA(oDATA), .oBUSY(oBUSY), .oADDR(oADDR),
        .oTIMEOUT(oTIMEOUT), .LCD_DONE(LCD_DONE), .oBUS_OWN(oBUS_OWN),
        .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: a request is a phase count 1..TOTAL from acceptance.
    logic       mActive = 1'b0;
    int         mPhase = 0;
    logic       mRsLat = 1'b0;
    logic [7:0] mCap = 8'h00;
    logic [7:0] mData = 8'h00;
    logic       mBusy = 1'b0;
    logic [6:0] mAddr = 7'h00;

    always @(posedge clk) begin
        if (reset) begin
            mActive <= 1'b0; mPhase <= 0; mRsLat <= 1'b0; mCap <= 8'h00;
            mData <= 8'h00; mBusy <= 1'b0; mAddr <= 7'h00;
        end else if (!mActive) begin
            if (iStart) begin
                mActive <= 1'b1; mPhase <= 1; mRsLat <= iRS;
            end
        end else if (mPhase == TOTAL) begin
            mActive <= 1'b0;
        end else begin
            mPhase <= mPhase + 1;
            if (mPhase == T_AS + T_EN) mCap <= LCD_DATA_IN;
            if (mPhase == TOTAL - 1) begin
                mData <= mCap;
                if (!mRsLat) begin
                    mBusy <= mCap[7];
                    mAddr <= mCap[6:0];
                end
            end
        end
    end

    // Activity monitors (cumulative; the stimulus snapshots them).
    int   enCnt = 0, rsCnt = 0, doneCnt = 0, enRise = 0, enFall = 0;
    logic prevEn = 1'b0;
    always @(negedge clk) begin
        prevEn <= LCD_EN;
        if (LCD_EN) enCnt <= enCnt + 1;
        if (LCD_RS) rsCnt <= rsCnt + 1;
        if (LCD_DONE) doneCnt <= doneCnt + 1;
        if (LCD_EN && !prevEn) enRise <= cyc;
        if (!LCD_EN && prevEn) enFall <= cyc;
    end

    int   nVec = 0, nErr = 0;
    logic modelOn = 1'b0;
    int   startCyc = 0, enBase = 0, rsBase = 0, doneBase = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_);
        nVec++;
        if (act !== exp_) begin
            nErr++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp_);
        end
    endtask

    task automatic startRead(input logic rs);
        @(posedge clk); #1;
        iStart = 1'b1; iRS = rs; startCyc = cyc;
        enBase = enCnt; rsBase = rsCnt;
        @(posedge clk); #1;
        iStart = 1'b0;
    endtask

    task automatic waitDone(input string nm, input int expLat);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (LCD_DONE === 1'b1) begin
                lat = cyc - startCyc;
                break;
            end
        end
        check(nm, 32'(lat), 32'(expLat));
    endtask

    initial begin
        int d1, d2;
        fork
            forever begin
                @(negedge clk);
                if (modelOn) begin
                    logic eEn, eRw, eOwn, eDone;
                    eEn   = mActive && mPhase >= T_AS + 1 && mPhase <= T_AS + T_EN;
                    eRw   = mActive && mPhase >= 1 && mPhase <= T_AS + T_EN + T_H;
                    eOwn  = mActive && mPhase <= TOTAL - 1;
                    eDone = mActive && mPhase == TOTAL;
                    check("LCD_EN", 32'(LCD_EN), 32'(eEn));
                    check("LCD_RW", 32'(LCD_RW), 32'(eRw));
                    check("LCD_RS", 32'(LCD_RS), 32'(eRw && mRsLat));
                    check("oBUS_OWN", 32'(oBUS_OWN), 32'(eOwn));
                    check("LCD_DONE", 32'(LCD_DONE), 32'(eDone));
                    check("oDATA", 32'(oDATA), 32'(mData));
                    check("oBUSY", 32'(oBUSY), 32'(mBusy));
                    check("oADDR", 32'(oADDR), 32'(mAddr));
                    check("oTIMEOUT", 32'(oTIMEOUT), 32'(0));
                end
            end
        join_none

        // Reset state
        @(posedge clk); #1;
        modelOn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst oDATA", 32'(oDATA), 32'h0);
        check("rst EN", 32'(LCD_EN), 32'h0);
        check("rst OWN", 32'(oBUS_OWN), 32'h0);
        check("rst DONE", 32'(LCD_DONE), 32'h0);

        // Status read of 0x45
        LCD_DATA_IN = 8'h45;
        startRead(1'b0);
        waitDone("status latency", 27);
        check("status oDATA", 32'(oDATA), 32'h45);
        check("status oBUSY", 32'(oBUSY), 32'h0);
        check("status oADDR", 32'(oADDR), 32'h45);
        check("EN first cycle", 32'(enRise - startCyc), 32'd3);
        check("EN last cycle", 32'(enFall - 1 - startCyc), 32'd14);
        check("EN width", 32'(enCnt - enBase), 32'd12);

        // Data read of 0x57; pins go to 0x00 after the sample point
        LCD_DATA_IN = 8'h57;
        startRead(1'b1);
        repeat (14) @(posedge clk);
        #1 LCD_DATA_IN = 8'h00;
        waitDone("data latency", 27);
        check("data oDATA", 32'(oDATA), 32'h57);
        check("data oBUSY kept", 32'(oBUSY), 32'h0);
        check("data oADDR kept", 32'(oADDR), 32'h45);
        check("RS width", 32'(rsCnt - rsBase), 32'd16);

        // Sample point: only the last EN-high cycle carries 0x3C
        LCD_DATA_IN = 8'hFF;
        startRead(1'b0);
        repeat (13) @(posedge clk);
        #1 LCD_DATA_IN = 8'h3C;
        @(posedge clk);
        #1 LCD_DATA_IN = 8'hFF;
        waitDone("sample latency", 27);
        check("sample oDATA", 32'(oDATA), 32'h3C);
        check("sample oADDR", 32'(oADDR), 32'h3C);

        // Busy flag set in a status read
        LCD_DATA_IN = 8'hA5;
        startRead(1'b0);
        waitDone("bf latency", 27);
        check("bf oBUSY", 32'(oBUSY), 32'h1);
        check("bf oADDR", 32'(oADDR), 32'h25);

        // Mid-cycle reset in cycle 8
        startRead(1'b1);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst EN", 32'(LCD_EN), 32'h0);
        check("midrst RW", 32'(LCD_RW), 32'h0);
        check("midrst OWN", 32'(oBUS_OWN), 32'h0);
        check("midrst oDATA", 32'(oDATA), 32'h0);
        doneBase = doneCnt;
        repeat (40) @(negedge clk);
        check("midrst no DONE", 32'(doneCnt - doneBase), 32'h0);
        LCD_DATA_IN = 8'h12;
        startRead(1'b0);
        waitDone("post-reset latency", 27);
        check("post-reset oADDR", 32'(oADDR), 32'h12);

        // Held iStart: back-to-back requests
        @(posedge clk); #1;
        iStart = 1'b1; iRS = 1'b1; startCyc = cyc;
        waitDone("held first", 27);
        d1 = cyc;
        d2 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (LCD_DONE === 1'b1) begin
                d2 = cyc;
                break;
            end
        end
        check("held period", 32'(d2 - d1), 32'd28);
        @(posedge clk); #1;
        iStart = 1'b0;
        repeat (5) @(negedge clk);
        check("held idle OWN", 32'(oBUS_OWN), 32'h0);

`ifdef LCD_BF_POLL_EN
        // Poll: BF=1 on reads 1-2, then 0x12
        modelOn = 1'b0;
        iPoll = 1'b1;
        LCD_DATA_IN = 8'h80;
        startRead(1'b0);
        repeat (30) @(posedge clk);
        #1 LCD_DATA_IN = 8'h12;
        waitDone("poll latency", 59);
        check("poll oBUSY", 32'(oBUSY), 32'h0);
        check("poll oADDR", 32'(oADDR), 32'h12);
        check("poll oTIMEOUT", 32'(oTIMEOUT), 32'h0);
        check("poll EN cycles", 32'(enCnt - enBase), 32'd36);

        // Poll timeout: BF stuck at 1
        LCD_DATA_IN = 8'h80;
        startRead(1'b0);
        waitDone("timeout latency", 59);
        check("timeout oTIMEOUT", 32'(oTIMEOUT), 32'h1);
        check("timeout oBUSY", 32'(oBUSY), 32'h1);
        check("timeout EN cycles", 32'(enCnt - enBase), 32'd36);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/lcd_read_controller.md
Name: lcd_read_controller

Overview:
- Read-side counterpart to the HD44780 write controller. Runs one 8-bit parallel read cycle (RW=1) per request.
- Returns either the busy flag and address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Sits beside the write controller under the LCD top level. `oBUS_OWN` tells the top-level mux to release the data-pin drivers and route RW/EN/RS from this block.

Parameters:
- T_AS, 2, clocks RS/RW held before EN rises (address setup); ≥1
- T_EN, 12, clocks EN held high; LCD_DATA_IN is sampled on the last of these; ≥1
- T_H, 2, clocks RS/RW held after EN falls; ≥1
- T_REC, 10, clocks of recovery with EN low before completion; ≥1
- POLL_MAX, 255, maximum busy-flag reads per request in poll mode (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iStart  in  1  read request; sampled only in IDLE
- iRS  in  1  register select for the read: 0 = busy flag/address, 1 = data
- iPoll  in  1  poll until not busy (optional feature; ignored otherwise)
- LCD_DATA_IN  in  8  LCD data pins as seen by the top-level tristate buffer
- oDATA  out  8  last byte read
- oBUSY  out  1  oDATA[7] from the last RS=0 read
- oADDR  out  7  oDATA[6:0] from the last RS=0 read
- oTIMEOUT  out  1  poll gave up (optional feature)
- LCD_DONE  out  1  one-cycle completion pulse
- oBUS_OWN  out  1  high from SETUP through RECOVER
- LCD_RW  out  1  high from SETUP through HOLD
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  iRS as latched at start

Behaviour:
- Reset (synchronous, takes priority in every state):
  - state → IDLE, counter → 0.
  - All outputs go to 0, including oDATA/oBUSY/oADDR.
  - If reset arrives mid-cycle, EN, RW and oBUS_OWN drop on the next edge; no LCD_DONE is issued.
- IDLE: if iStart=1, latch iRS (and iPoll) and go to SETUP. Otherwise stay, with RW/EN/RS/oBUS_OWN all 0.
- SETUP: RS=latched value, RW=1, EN=0, for T_AS cycles → EN_HI.
- EN_HI: EN=1 for T_EN cycles.
  - On the final cycle's rising edge, LCD_DATA_IN is captured into an internal register.
  - Then go to HOLD.
- HOLD: EN=0, RW=1, RS held, for T_H cycles → RECOVER.
- RECOVER: RW=0, EN=0, oBUS_OWN=1, for T_REC cycles → DONE.
- DONE (one cycle):
  - LCD_DONE=1 and oBUS_OWN=0.
  - oDATA is loaded from the capture register.
  - If RS=0, oBUSY and oADDR are loaded; if RS=1 they are unchanged.
  - Next state is IDLE.
  - oDATA holds until the next DONE.
- Latency with defaults: iStart high in cycle 0 → SETUP cycles 1–2, EN cycles 3–14, HOLD 15–16, RECOVER 17–26, LCD_DONE in cycle 27. In general, LCD_DONE falls in cycle 1+T_AS+T_EN+T_H+T_REC.
- iStart outside IDLE is ignored, with no queuing. An iStart held high starts a new read in the cycle after DONE.
- One down-counter serves all timed states: loaded with (param−1) on state entry; transition when it reads 0. Width is $clog2 of the largest timing parameter plus 1.
- EN never rises while RS/RW are changing. RS/RW are stable for the whole of SETUP..HOLD.

Optional Feature:
- Macro: `LCD_BF_POLL_EN`.
- With the macro, when the latched iPoll=1 and RS=0:
  - In the cycle after HOLD, the captured bit 7 is checked. If it is 1, go back to SETUP and increment the poll count; RECOVER and DONE are skipped for that read.
  - If bit 7 is 0, go through RECOVER to DONE with oTIMEOUT=0.
  - After POLL_MAX reads with BF still 1, go to DONE with oTIMEOUT=1; oBUSY=1 in that case.
  - The poll count clears in IDLE.
  - oTIMEOUT holds until the next DONE.
- Without the macro: iPoll is unused and oTIMEOUT is tied to 0; every request is a single read.

Decomposition:
- Package `lcd_pkg` holds:
  - the state enum (IDLE, SETUP, EN_HI, HOLD, RECOVER, DONE);
  - default timing constants T_AS/T_EN/T_H/T_REC;
  - HD44780 command constants shared with the write sequencer (0x38 function set, 0x0C display on, 0x01 clear, 0x06 entry mode, 0x80/0xC0 line addresses);
  - the BF bit index (7).
- Sub-module `lcd_cycle_timer`: a loadable down-counter with an expire flag, reusable by the write controller.

Test Plan:
- Status read: reset, iStart=1 for one cycle with iRS=0, LCD_DATA_IN=8'h45 → LCD_DONE pulse in cycle 27; oDATA=8'h45, oBUSY=0, oADDR=7'h45; EN high for exactly cycles 3–14.
- Data read: iRS=1, LCD_DATA_IN=8'h57, then later LCD_DATA_IN=8'h00 → LCD_RS=1 from SETUP through HOLD; oDATA=8'h57; oBUSY/oADDR unchanged.
- Sample point: LCD_DATA_IN=8'hFF until the last EN_HI cycle, then 8'h3C for that cycle → oDATA equals the value present at the EN falling edge.
- Mid-cycle reset: reset asserted in cycle 8 → next edge gives EN=0, RW=0, oBUS_OWN=0; no LCD_DONE; a fresh iStart completes in exactly 27 cycles.
- Held iStart: iStart tied high → back-to-back DONE pulses every 28 cycles; no start is accepted while busy.
- Poll (`LCD_BF_POLL_EN`, POLL_MAX=3): BF=1 on reads 1–2, then 8'h12 → a single DONE with oBUSY=0, oTIMEOUT=0; with BF stuck at 1 → DONE after 3 reads with oTIMEOUT=1.
